// File: rtl/vmatmul_seq.sv
// vmatmul_seq: loop sequencer for the vector matrix-multiply path.
// Walks i (outer), j, k (inner) and issues one triple per accepted step.
module vmatmul_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] num_i,
    input  logic [31:0] num_j,
    input  logic [31:0] num_k,
    input  logic        ready,
    output logic        valid,
    output logic [31:0] i,
    output logic [31:0] j,
    output logic [31:0] k,
    output logic        first_iter,
    output logic        first_k,
    output logic        last_k,
    output logic        advance_j,
    output logic        advance_i,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [31:0] shape_i;
    logic [31:0] shape_j;
    logic [31:0] shape_k;
    logic        k_end;
    logic        j_end;
    logic        i_end;
    logic        accept;

    // Loop-end compares; shapes are nonzero whenever RUN is entered.
    assign k_end = (k == shape_k - 32'd1);
    assign j_end = (j == shape_j - 32'd1);
    assign i_end = (i == shape_i - 32'd1);

    assign valid  = (state == RUN);
    assign busy   = (state != IDLE);
    assign done   = (state == DONE);
    assign accept = valid && ready;

    // Step flags are only meaningful with valid, so they are gated by it.
    assign first_iter = valid && (i == 32'd0) && (j == 32'd0) && (k == 32'd0);
    assign first_k    = valid && (k == 32'd0);
    assign last_k     = valid && k_end;
    assign advance_j  = last_k;
    assign advance_i  = last_k && j_end;

    // Sequencer FSM: latch shape on start, step the triple loop on accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            shape_i <= 32'd0;
            shape_j <= 32'd0;
            shape_k <= 32'd0;
            i       <= 32'd0;
            j       <= 32'd0;
            k       <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shape_i <= num_i;
                        shape_j <= num_j;
                        shape_k <= num_k;
                        i       <= 32'd0;
                        j       <= 32'd0;
                        k       <= 32'd0;
                        if ((num_i == 32'd0) || (num_j == 32'd0) ||
                            (num_k == 32'd0))
                            state <= DONE;
                        else
                            state <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (!k_end) begin
                            k <= k + 32'd1;
                        end else if (!j_end) begin
                            k <= 32'd0;
                            j <= j + 32'd1;
                        end else if (!i_end) begin
                            k <= 32'd0;
                            j <= 32'd0;
                            i <= i + 32'd1;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vmatmul_seq.sv
// tb_vmatmul_seq: directed table-driven bench for vmatmul_seq.
// Expected step sequences are hand-written records compared per accept.
module tb_vmatmul_seq;
    logic        clk = 1'b0;
    logic        reset, start, ready;
    logic [31:0] num_i, num_j, num_k;
    logic        valid, first_iter, first_k, last_k;
    logic        advance_j, advance_i, busy, done;
    logic [31:0] i, j, k;

    typedef struct packed {
        logic [31:0] si;
        logic [31:0] sj;
        logic [31:0] sk;
        logic        fi;
        logic        fk;
        logic        lk;
        logic        aj;
        logic        ai;
    } step_t;

    step_t tab [64];
    int    total = 0;
    int    bad   = 0;

    vmatmul_seq dut (
        .clk(clk), .reset(reset), .start(start),
        .num_i(num_i), .num_j(num_j), .num_k(num_k),
        .ready(ready), .valid(valid), .i(i), .j(j), .k(k),
        .first_iter(first_iter), .first_k(first_k), .last_k(last_k),
        .advance_j(advance_j), .advance_i(advance_i),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string nm,
                       input logic [103:0] act, input logic [103:0] exp_v);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    function automatic step_t cur();
        step_t s;
        s = '{si: i, sj: j, sk: k, fi: first_iter, fk: first_k,
              lk: last_k, aj: advance_j, ai: advance_i};
        return s;
    endfunction

    // Launch one operation, compare each presented step, check done timing.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input int exp_steps,
                          input int exp_done, input int stall_at,
                          input int stall_len, input int restart_at,
                          input string nm);
        int idx;
        int stalls;
        int got_done;
        step_t s;
        idx = 0;
        stalls = 0;
        got_done = -1;
        ready = 1'b1;
        start = 1'b1;
        num_i = a;
        num_j = b;
        num_k = c;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (n == restart_at) begin
                start = 1'b1;
                num_i = 32'd1;
                num_j = 32'd1;
                num_k = 32'd1;
            end
            if (done) begin
                got_done = n;
                chk(busy && !valid && !first_iter && !first_k && !last_k &&
                    !advance_j && !advance_i,
                    {nm, " done-cycle outputs"},
                    {busy, valid, first_iter, first_k, last_k,
                     advance_j, advance_i}, 104'h40);
                break;
            end
            if (valid) begin
                s = cur();
                if (idx < exp_steps)
                    chk(s == tab[idx], {nm, " step"}, s, tab[idx]);
                else
                    chk(1'b0, {nm, " extra step"}, s, 104'h0);
                if (idx == stall_at && stalls < stall_len) begin
                    ready = 1'b0;
                    stalls++;
                end else begin
                    ready = 1'b1;
                    idx++;
                end
            end
        end
        ready = 1'b1;
        start = 1'b0;
        chk(got_done == exp_done, {nm, " done latency"},
            104'(got_done), 104'(exp_done));
        chk(idx == exp_steps, {nm, " step count"},
            104'(idx), 104'(exp_steps));
        @(posedge clk);
        #1;
        chk(!done && !busy && !valid, {nm, " back to idle"},
            {done, busy, valid}, 104'h0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        ready = 1'b1;
        num_i = 32'd0;
        num_j = 32'd0;
        num_k = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk({valid, busy, done, first_iter, first_k, last_k, advance_j,
             advance_i} == 8'h0 && i == 0 && j == 0 && k == 0,
            "reset state", {valid, busy, done, i, j, k}, 104'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 2x2x2
        tab[0] = '{0, 0, 0, 1, 1, 0, 0, 0};
        tab[1] = '{0, 0, 1, 0, 0, 1, 1, 0};
        tab[2] = '{0, 1, 0, 0, 1, 0, 0, 0};
        tab[3] = '{0, 1, 1, 0, 0, 1, 1, 1};
        tab[4] = '{1, 0, 0, 0, 1, 0, 0, 0};
        tab[5] = '{1, 0, 1, 0, 0, 1, 1, 0};
        tab[6] = '{1, 1, 0, 0, 1, 0, 0, 0};
        tab[7] = '{1, 1, 1, 0, 0, 1, 1, 1};
        run_op(2, 2, 2, 8, 9, -1, 0, -1, "s222");

        // 1x1x1
        tab[0] = '{0, 0, 0, 1, 1, 1, 1, 1};
        run_op(1, 1, 1, 1, 2, -1, 0, -1, "s111");

        // 2x3x1 with a 3-cycle stall at (0,2,0)
        tab[0] = '{0, 0, 0, 1, 1, 1, 1, 0};
        tab[1] = '{0, 1, 0, 0, 1, 1, 1, 0};
        tab[2] = '{0, 2, 0, 0, 1, 1, 1, 1};
        tab[3] = '{1, 0, 0, 0, 1, 1, 1, 0};
        tab[4] = '{1, 1, 0, 0, 1, 1, 1, 0};
        tab[5] = '{1, 2, 0, 0, 1, 1, 1, 1};
        run_op(2, 3, 1, 6, 10, 2, 3, -1, "s231");

        // zero dimension
        run_op(4, 0, 4, 0, 1, -1, 0, -1, "zero_j");

        // 3x3x3 with an ignored start pulse mid-run
        for (int a = 0; a < 3; a++)
            for (int b = 0; b < 3; b++)
                for (int c = 0; c < 3; c++)
                    tab[a * 9 + b * 3 + c] =
                        '{a, b, c, (a == 0 && b == 0 && c == 0), (c == 0),
                          (c == 2), (c == 2), (c == 2 && b == 2)};
        run_op(3, 3, 3, 27, 28, -1, 0, 5, "s333");

        // reset during the fifth step of a fresh run
        start = 1'b1;
        num_i = 32'd3;
        num_j = 32'd3;
        num_k = 32'd3;
        for (int n = 1; n <= 5; n++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        chk(valid && i == 0 && j == 1 && k == 1, "pre-reset step5",
            {valid, i, j, k}, {1'b1, 32'd0, 32'd1, 32'd1});
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk(!valid && !busy && !done && i == 0 && j == 0 && k == 0,
            "abort by reset", {valid, busy, done, i, j, k}, 104'h0);
        for (int n = 0; n < 4; n++) begin
            @(posedge clk);
            #1;
            chk(!done && !valid, "no done after abort",
                {done, valid}, 104'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vmatmul_seq.md
# vmatmul_seq

Loop-sequencing controller for the vector matrix-multiply path. Accepts a start command with matrix shape, then walks the triple loop (i outer, j middle, k inner) and issues one index triple per accepted step to the datapath stage downstream, along with its advance/first-iteration flags. Issue is valid/ready, so the downstream stage can stall the sequence. Completion is reported with a one-cycle done pulse.

## Interface
- No parameters; all index and shape widths fixed at 32 bits.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clears all state
- start  in  1  command strobe, sampled only in IDLE
- num_i  in  32  rows of A and C (unsigned)
- num_j  in  32  columns of B and C (unsigned)
- num_k  in  32  columns of A / rows of B, the inner dot-product length (unsigned)
- ready  in  1  downstream accepts the current step
- valid  out  1  step (i, j, k) is presented
- i, j, k  out  32 each  current step indices
- first_iter  out  1  current step is the first of the whole operation (0,0,0)
- first_k  out  1  k == 0; downstream clears the partial sum
- last_k  out  1  k == num_k-1; downstream commits C[i][j]
- advance_j  out  1  the next step increments j (equals last_k)
- advance_i  out  1  the next step increments i (last_k and j == num_j-1)
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, RUN, DONE.
- IDLE: valid=0, busy=0. On start=1, latch num_i/num_j/num_k and clear i=j=k=0.
  - If any dimension is 0, go to DONE. No step is issued.
  - Otherwise go to RUN.
- RUN: valid=1. A step is accepted when valid && ready. On accept:
  - If k < num_k-1: k <= k+1.
  - Else if j < num_j-1: k <= 0, j <= j+1.
  - Else if i < num_i-1: k <= 0, j <= 0, i <= i+1.
  - Else (final step, advance_i=1 with i==num_i-1): go to DONE.
- While ready=0, i/j/k and all flags hold stable and valid stays 1.
- DONE: valid=0, done=1 for exactly one cycle, then return to IDLE.
- Flags are combinational from the latched shape and registered indices. They are meaningful only while valid=1 and are forced to 0 when valid=0.
- first_iter is 1 only while i=j=k=0 in RUN. It stays 1 across stalls and drops after the first accept.
- Index comparisons are unsigned 32-bit. Shape inputs are ignored outside the start cycle, so changing num_* mid-run has no effect.
- start while busy is ignored and not queued.
- Total accepted steps per operation = num_i*num_j*num_k. Products are never computed in hardware; only per-loop compares are used.

## Timing
- Reset: state=IDLE. valid, busy, done, first_iter, first_k, last_k, advance_i, advance_j are 0. i=j=k=0.
- Reset asserted mid-RUN aborts at the next edge: no done pulse, and outputs return to their reset values.
- start sampled at edge N (IDLE):
  - valid=1 with (0,0,0) from cycle N+1.
  - With a zero dimension, done=1 in cycle N+1 instead.
- ready held high: one step per cycle. The last step is accepted at edge N+S, where S = num_i*num_j*num_k. done=1 in cycle N+S+1, and IDLE is reached at N+S+2.
- A new start is accepted at earliest in the cycle after done, i.e. in IDLE.
- Each stall cycle (ready=0) delays everything after it by exactly one cycle.

## Test plan
- Shape 2x2x2 (num_i=num_j=num_k=2), ready=1:
  - Issued sequence is (0,0,0),(0,0,1),(0,1,0),(0,1,1),(1,0,0),(1,0,1),(1,1,0),(1,1,1).
  - first_iter only on the first step.
  - last_k/advance_j on odd-k steps.
  - advance_i on (0,1,1) and (1,1,1).
  - done exactly 9 cycles after start.
- Shape 1x1x1:
  - A single step with first_iter=first_k=last_k=advance_j=advance_i=1.
  - done 2 cycles after start.
- Shape 2x3x1, with ready low for 3 cycles at step (0,2,0):
  - Step (0,2,0) holds stable with valid=1 throughout the stall.
  - 6 steps total, each with first_k=last_k=1.
  - done 10 cycles after start.
- num_j=0:
  - valid never asserts.
  - done pulses in the cycle after start, and busy is high only that cycle.
- Start 3x3x3, then pulse start again with num_*=1 mid-run:
  - The second start is ignored and all 27 steps complete with the original shape.
  - Then assert reset at step 5 of a fresh run: next cycle valid=0, i=j=k=0, busy=0, and no done pulse.
